// File: rtl/arb2_rr_mux.sv
// arb2_rr_mux: two-input round-robin packet arbiter with registered output stage
// Grants one of two valid/ready/last sources, locks the grant for the whole
// packet, and forwards the selected beat through a single output register.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in0_* / in1_*                 source beats (valid, data, last) and ready back
//   sel                           current grant, drives the downstream data mux
//   out_valid/out_data/out_last   registered output beat, out_ready from consumer
// Build option: ARB2_FIXED_PRIO_EN makes in0 always win an idle contention.
module arb2_rr_mux #(
  parameter int WIDTH          = 8,
  parameter bit LAST_GRANT_RST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t state, state_nxt;
  logic last_grant, idle_sel, load_en, xfer, mux_last;
  logic [WIDTH-1:0] mux_data;
  always_comb begin
    load_en = !out_valid || out_ready;
`ifdef ARB2_FIXED_PRIO_EN
    idle_sel = in0_valid ? 1'b0 : in1_valid ? 1'b1 : last_grant;
`else
    idle_sel = (in0_valid && in1_valid) ? ~last_grant : in0_valid ? 1'b0 : in1_valid ? 1'b1 : last_grant;
`endif
    sel = state == LOCK0 ? 1'b0 : state == LOCK1 ? 1'b1 : idle_sel;
    in0_ready = load_en && !sel;
    in1_ready = load_en && sel;
    xfer = sel ? in1_valid && in1_ready : in0_valid && in0_ready;
    mux_data = sel ? in1_data : in0_data;
    mux_last = sel ? in1_last : in0_last;
    state_nxt = !xfer ? state : mux_last ? IDLE : sel ? LOCK1 : LOCK0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LAST_GRANT_RST;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) last_grant <= sel;
      if (load_en) out_valid <= xfer;
      if (xfer) begin
        out_data <= mux_data;
        out_last <= mux_last;
      end
    end
  end
endmodule

// File: tb/tb_arb2_rr_mux.sv
// tb_arb2_rr_mux: directed table-driven bench for arb2_rr_mux
module tb_arb2_rr_mux;
`ifdef ARB2_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  typedef struct {
    logic rst, v0, l0, v1, l1, ordy;
    logic [7:0] d0, d1;
    logic esel, er0, er1, eov, eol;
    logic [7:0] eod;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in0_valid = 0, in0_last = 0, in1_valid = 0, in1_last = 0, out_ready = 0;
  logic [7:0] in0_data = 0, in1_data = 0;
  logic in0_ready, in1_ready, sel, out_valid, out_last;
  logic [7:0] out_data;
  int errors = 0, checks = 0;
  vec_t tbl [19];
  always #5 clk = ~clk;
  arb2_rr_mux #(.WIDTH(8), .LAST_GRANT_RST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );
  function automatic vec_t mk(logic r, logic v0, logic [7:0] d0, logic l0, logic v1, logic [7:0] d1,
                              logic l1, logic o, logic s, logic r0, logic r1, logic ov, logic [7:0] od, logic ol);
    vec_t t;
    t.rst = r; t.v0 = v0; t.d0 = d0; t.l0 = l0; t.v1 = v1; t.d1 = d1; t.l1 = l1; t.ordy = o;
    t.esel = s; t.er0 = r0; t.er1 = r1; t.eov = ov; t.eod = od; t.eol = ol;
    return t;
  endfunction
  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1, input logic o);
    rst = r; in0_valid = v0; in0_data = d0; in0_last = l0;
    in1_valid = v1; in1_data = d1; in1_last = l1; out_ready = o;
  endtask
  initial begin
    // contention with single-beat packets
    tbl[0]  = mk(0, 1, 8'h11, 1, 1, 8'h22, 1, 1,  0, 1, 0,  1, 8'h11, 1);
    tbl[1]  = mk(0, 1, 8'h11, 1, 1, 8'h22, 1, 1,  !FP, FP, !FP,  1, FP ? 8'h11 : 8'h22, 1);
    // 3-beat packet on in0 while in1 waits
    tbl[2]  = mk(0, 1, 8'hA0, 0, 1, 8'hB0, 1, 1,  0, 1, 0,  1, 8'hA0, 0);
    tbl[3]  = mk(0, 1, 8'hA1, 0, 1, 8'hB0, 1, 1,  0, 1, 0,  1, 8'hA1, 0);
    tbl[4]  = mk(0, 1, 8'hA2, 1, 1, 8'hB0, 1, 1,  0, 1, 0,  1, 8'hA2, 1);
    tbl[5]  = mk(0, 0, 8'h00, 0, 1, 8'hB0, 1, 1,  1, 0, 1,  1, 8'hB0, 1);
    // owner stalls mid-packet for 2 cycles, lock held
    tbl[6]  = mk(0, 1, 8'hC0, 0, 1, 8'hD0, 1, 1,  0, 1, 0,  1, 8'hC0, 0);
    tbl[7]  = mk(0, 0, 8'h00, 0, 1, 8'hD0, 1, 1,  0, 1, 0,  0, 8'hC0, 0);
    tbl[8]  = mk(0, 0, 8'h00, 0, 1, 8'hD0, 1, 1,  0, 1, 0,  0, 8'hC0, 0);
    tbl[9]  = mk(0, 1, 8'hC1, 1, 1, 8'hD0, 1, 1,  0, 1, 0,  1, 8'hC1, 1);
    tbl[10] = mk(0, 0, 8'h00, 0, 1, 8'hD0, 1, 1,  1, 0, 1,  1, 8'hD0, 1);
    // backpressure for 3 cycles, then full throughput
    tbl[11] = mk(0, 1, 8'hE0, 1, 0, 8'h00, 0, 0,  0, 0, 0,  1, 8'hD0, 1);
    tbl[12] = mk(0, 1, 8'hE0, 1, 0, 8'h00, 0, 0,  0, 0, 0,  1, 8'hD0, 1);
    tbl[13] = mk(0, 1, 8'hE0, 1, 0, 8'h00, 0, 0,  0, 0, 0,  1, 8'hD0, 1);
    tbl[14] = mk(0, 1, 8'hE0, 1, 1, 8'hF0, 1, 1,  0, 1, 0,  1, 8'hE0, 1);
    tbl[15] = mk(0, 1, 8'hE1, 1, 1, 8'hF0, 1, 1,  !FP, FP, !FP,  1, FP ? 8'hE1 : 8'hF0, 1);
    // reset during LOCK1, then contention goes to in0
    tbl[16] = mk(0, 0, 8'h00, 0, 1, 8'h60, 0, 1,  1, 0, 1,  1, 8'h60, 0);
    tbl[17] = mk(1, 1, 8'h70, 1, 1, 8'h61, 0, 1,  1, 0, 1,  0, 8'h00, 0);
    tbl[18] = mk(0, 1, 8'h70, 1, 1, 8'h61, 1, 1,  0, 1, 0,  1, 8'h70, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rst_out_valid", -1, {7'd0, out_valid}, 8'd0);
    chk("rst_out_data", -1, out_data, 8'd0);
    chk("rst_out_last", -1, {7'd0, out_last}, 8'd0);
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].l0, tbl[i].v1, tbl[i].d1, tbl[i].l1, tbl[i].ordy);
      #1;
      chk("sel", i, {7'd0, sel}, {7'd0, tbl[i].esel});
      chk("in0_ready", i, {7'd0, in0_ready}, {7'd0, tbl[i].er0});
      chk("in1_ready", i, {7'd0, in1_ready}, {7'd0, tbl[i].er1});
      @(posedge clk); #1;
      chk("out_valid", i, {7'd0, out_valid}, {7'd0, tbl[i].eov});
      chk("out_data", i, out_data, tbl[i].eod);
      chk("out_last", i, {7'd0, out_last}, {7'd0, tbl[i].eol});
    end
    // both inputs continuously valid: alternate under round-robin, in0 only under fixed priority
    for (int k = 0; k < 6; k++) begin
      logic es;
      es = FP ? 1'b0 : (k % 2 == 0);
      drive(0, 1, 8'h30 + 8'(k), 1, 1, 8'h40 + 8'(k), 1, 1);
      #1;
      chk("cont_sel", 100 + k, {7'd0, sel}, {7'd0, es});
      @(posedge clk); #1;
      chk("cont_out_valid", 100 + k, {7'd0, out_valid}, 8'd1);
      chk("cont_out_data", 100 + k, out_data, es ? 8'h40 + 8'(k) : 8'h30 + 8'(k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arb2_rr_mux.md
Name: arb2_rr_mux

Overview:
- Two-input round-robin packet arbiter with a registered output stage. It generates the select line for the downstream 2-to-1 data multiplexer and forwards the selected beat.
- Each source presents beats with valid/ready/last. Once a packet is granted, the grant is locked until its last beat transfers.
- Sits between two producers and a single consumer.

Parameters:
WIDTH, 8, data width of each input and of the output
LAST_GRANT_RST, 1, value of the last-grant register after reset; 1 means in0 wins the first contended arbitration

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in0_valid  input  1  source 0 beat valid
in0_data  input  WIDTH  source 0 beat data
in0_last  input  1  source 0 final beat of packet
in0_ready  output  1  source 0 beat accepted this cycle when high with in0_valid
in1_valid  input  1  source 1 beat valid
in1_data  input  WIDTH  source 1 beat data
in1_last  input  1  source 1 final beat of packet
in1_ready  output  1  source 1 beat accepted
sel  output  1  current grant; 0 selects in0, 1 selects in1; drives the data mux
out_valid  output  1  registered output beat valid
out_data  output  WIDTH  registered output data
out_last  output  1  registered output last flag
out_ready  input  1  consumer accepts output beat

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, state=IDLE, last_grant=LAST_GRANT_RST.
- States:
  - IDLE: no packet in progress.
  - LOCK0: in0 owns the grant.
  - LOCK1: in1 owns the grant.
- Load enable: load_en = !out_valid || out_ready. Register loads on load_en; one beat per cycle at full throughput; 1-cycle latency from input transfer to out_valid.
- Grant decision in IDLE:
  - Only one valid: that input wins.
  - Both valid: winner = ~last_grant.
  - Neither valid: sel = last_grant, no transfer.
- Grant in LOCK0/LOCK1: fixed to the owner, regardless of the other input.
- sel: combinational, equal to the current grant (IDLE decision or lock owner).
- Ready: inX_ready = load_en && (sel==X). The non-granted ready is always 0.
- Transfer: inX_valid && inX_ready.
  - On transfer, out_data/out_last load from the mux output and out_valid is set to 1.
  - If load_en is high with no transfer, out_valid is cleared to 0.
- last_grant updates to the winner on every transfer.
- Transitions:
  - IDLE → LOCKx on a transfer with last=0.
  - IDLE stays IDLE on a single-beat packet (last=1).
  - LOCKx → IDLE on a transfer with last=1.
  - LOCKx stays in LOCKx while the owner stalls (valid low); the other input is never granted mid-packet.
- Backpressure: while out_valid=1 and out_ready=0, out_valid/out_data/out_last hold, and both readies are 0.
- Simultaneous events: an output drain and a new load in the same cycle are allowed (load_en high via out_ready).
- Reset mid-packet: state returns to IDLE, the output beat is discarded, and the lock is released in the same cycle.

Optional Feature:
- Macro: ARB2_FIXED_PRIO_EN.
- Defined: the IDLE contention rule becomes in0 always wins; last_grant is still tracked but ignored for decisions; packet locking is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset with LAST_GRANT_RST=1; both valid, single-beat packets, in0_data=0x11, in1_data=0x22, out_ready=1 → outputs 0x11 then 0x22 on consecutive cycles; sel toggles 0,1.
- in0 sends a 3-beat packet A0,A1,A2 (last on A2) while in1 holds valid with B0 → output sequence A0,A1,A2,B0; in1_ready=0 until A2 transfers.
- Lock held while the owner stalls mid-packet for 2 cycles with in1 valid → state stays LOCK0, no in1 beat emitted, and the packet resumes when in0_valid returns.
- out_ready=0 for 3 cycles with out_valid=1 → out_data stable, in0_ready=in1_ready=0; after out_ready=1, throughput resumes at one beat per cycle.
- Assert rst during LOCK1 → next cycle out_valid=0 and state=IDLE; a subsequent contention is granted to in0.
- With ARB2_FIXED_PRIO_EN defined, both inputs continuously valid with single-beat packets → only in0 beats are output (in1 starved).
